// File: rtl/seq_divider_pkg.sv
// Shared definitions for the multi-cycle restoring divider:
// default width, FSM state encodings, divide-by-zero result and counter width.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Control-unit <-> divider handshake bundle.
// master drives start/signed_op/dividend/divisor; slave returns
// busy/done/quotient/remainder/div_by_zero.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration.
// p_i: partial remainder, bit_i: next dividend bit, dmag_i: divisor magnitude;
// p_o: next partial remainder, qbit_o: quotient bit (NOT borrow).
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   p_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dmag_i,
    output logic [WIDTH:0]   p_o,
    output logic             qbit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    // One extra guard bit so the borrow of the trial subtraction is explicit.
    assign shifted = {p_i, bit_i};
    assign diff    = shifted - {2'b00, dmag_i};
    assign borrow  = diff[WIDTH+1];
    assign p_o     = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
    assign qbit_o  = ~borrow;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (DIV/DIVU): quotient to LO, remainder to HI.
// Ports: clk, clr (async active-high reset), bus (slave side of seq_divider_if).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         clr,
    seq_divider_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic             neg_a, neg_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   step_p;
    logic             step_bit;

    assign neg_a = bus.signed_op & bus.dividend[WIDTH-1];
    assign neg_b = bus.signed_op & bus.divisor[WIDTH-1];
    // Negating 0x80000000 yields itself, read as the unsigned magnitude 2^31.
    assign a_mag = neg_a ? -bus.dividend : bus.dividend;
    assign b_mag = neg_b ? -bus.divisor : bus.divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_i    (p_q),
        .bit_i  (q_q[WIDTH-1]),
        .dmag_i (dmag_q),
        .p_o    (step_p),
        .qbit_o (step_bit)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            dmag_q  <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dmag_q  <= dmag_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        dmag_d  = dmag_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;

        unique case (state_q)
            IDLE: begin
                // The done cycle closes the previous operation; a start
                // seen alongside done is dropped.
                if (bus.start && !done_q) begin
                    busy_d = 1'b1;
                    quo_d  = '0;
                    rem_d  = '0;
                    dbz_d  = 1'b0;
                    p_d    = '0;
                    qneg_d = neg_a ^ neg_b;
                    rneg_d = neg_a;
                    dmag_d = b_mag;
                    if (bus.divisor == '0) begin
                        // Raw dividend parked in Q for the remainder.
                        zero_d  = 1'b1;
                        q_d     = bus.dividend;
                        state_d = FIXUP;
                    end else begin
                        zero_d  = 1'b0;
                        q_d     = a_mag;
                        cnt_d   = CW'(WIDTH);
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                p_d   = step_p;
                q_d   = {q_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
                if (zero_q) begin
                    quo_d = DIV_ZERO_QUOTIENT;
                    rem_d = q_q;
                    dbz_d = 1'b1;
                end else begin
                    quo_d = qneg_q ? -q_q : q_q;
                    rem_d = rneg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed DIV/DIVU vectors,
// latency, ignored-start, divide-by-zero and async clear scenarios.
module tb_seq_divider;

    typedef struct {
        string       name;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic clk;
    logic clr;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t mon_e;

    seq_divider_if bus ();

    seq_divider dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!clr && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected done=0");
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_quot"}, bus.quotient, mon_e.q);
                chk({mon_e.name, "_rem"}, bus.remainder, mon_e.r);
                chk({mon_e.name, "_dbz"}, 32'(bus.div_by_zero),
                    32'(mon_e.dbz));
                chk({mon_e.name, "_lat"}, 32'(cyc), 32'(mon_e.cyc));
                chk({mon_e.name, "_busy_end"}, 32'(bus.busy), 0);
            end
        end
    end

    task automatic start_op(input string n, input logic s,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] q, input logic [31:0] r,
                            input logic dz, input bit push);
        exp_t e;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.signed_op = s;
        bus.dividend  = a;
        bus.divisor   = b;
        e.name = n;
        e.q    = q;
        e.r    = r;
        e.dbz  = dz;
        e.cyc  = cyc + ((b == 0) ? 2 : 34);
        if (push) sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        chk({n, "_busy"}, 32'(bus.busy), 1);
        chk({n, "_dbz_clr"}, 32'(bus.div_by_zero), 0);
        chk({n, "_quot_clr"}, bus.quotient, 0);
    endtask

    task automatic wait_done(input string n);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got pending=%0d expected 0",
                     n, sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input string n, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r,
                       input logic dz);
        start_op(n, s, a, b, q, r, dz, 1'b1);
        wait_done(n);
    endtask

    initial begin
        exp_t e;
        bit   seen;
        checks        = 0;
        errors        = 0;
        clr           = 1'b1;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_dbz", 32'(bus.div_by_zero), 0);
        chk("rst_quot", bus.quotient, 0);
        chk("rst_rem", bus.remainder, 0);
        clr = 1'b0;

        run("u100_7", 0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        run("sm100_7", 1, 32'hFFFFFF9C, 32'd7,
            32'hFFFFFFF2, 32'hFFFFFFFE, 0);
        run("s100_m7", 1, 32'd100, 32'hFFFFFFF9,
            32'hFFFFFFF2, 32'd2, 0);
        run("sm100_m7", 1, 32'hFFFFFF9C, 32'hFFFFFFF9,
            32'd14, 32'hFFFFFFFE, 0);
        run("u_max_msb", 0, 32'hFFFFFFFF, 32'h80000000,
            32'd1, 32'h7FFFFFFF, 0);
        run("s_ovf", 1, 32'h80000000, 32'hFFFFFFFF,
            32'h80000000, 32'd0, 0);
        run("u7_100", 0, 32'd7, 32'd100, 32'd0, 32'd7, 0);
        run("u_max_1", 0, 32'hFFFFFFFF, 32'd1,
            32'hFFFFFFFF, 32'd0, 0);
        run("dz_u", 0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1);
        run("dz_s", 1, 32'hFFFFFF9C, 32'd0,
            32'hFFFFFFFF, 32'hFFFFFF9C, 1);
        run("u0_5", 0, 32'd0, 32'd5, 32'd0, 32'd0, 0);

        // Start pulsed mid-operation with other operands is ignored.
        start_op("ign", 0, 32'd1000, 32'd3, 32'd333, 32'd1, 0, 1'b1);
        repeat (8) @(negedge clk);
        bus.start     = 1'b1;
        bus.signed_op = 1'b1;
        bus.dividend  = 32'd9;
        bus.divisor   = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ign");

        // Start held across done: dropped with done, taken one cycle later.
        start_op("dn1", 0, 32'd77, 32'd8, 32'd9, 32'd5, 0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("dn1_seen", 32'(seen), 1);
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd200;
        bus.divisor   = 32'd9;
        @(negedge clk);
        e.name = "dn2";
        e.q    = 32'd22;
        e.r    = 32'd2;
        e.dbz  = 1'b0;
        e.cyc  = cyc + 34;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("dn2");

        // Asynchronous clear in the middle of an operation.
        start_op("clr", 0, 32'd1000, 32'd3, 32'd0, 32'd0, 0, 1'b0);
        repeat (13) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("clr_busy", 32'(bus.busy), 0);
        chk("clr_done", 32'(bus.done), 0);
        chk("clr_dbz", 32'(bus.div_by_zero), 0);
        chk("clr_quot", bus.quotient, 0);
        chk("clr_rem", bus.remainder, 0);
        @(negedge clk);
        clr = 1'b0;
        run("u50_5", 0, 32'd50, 32'd5, 32'd10, 32'd0, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
